// File: rtl/bcd_converter_seq_if.sv
// Handshake bundle between a binary producer and the sequential BCD converter.
// With BCD_BLANK_EN defined the bundle also carries the leading-zero blank mask.
interface bcd_converter_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic                  busy;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, overflow, busy, blank
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, overflow, busy, blank
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, overflow, busy
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, overflow, busy
  );
`endif
endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional leading-zero blank mask enabled by defining BCD_BLANK_EN.
module bcd_converter_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  bcd_converter_seq_if.slave bus
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_corr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               upper_zero;
`endif

  // Add 3 to every digit that is 5 or more; the result stays within 4 bits.
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    res = acc;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  assign acc_corr = add3_digits(acc_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef BCD_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          bin_d      = bus.in_data;
          acc_d      = '0;
          ovf_d      = 1'b0;
          cnt_d      = CNT_W'(BIN_W);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A bit leaving the top digit is a decimal carry out of the result.
        acc_d = {acc_corr[ACC_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        ovf_d = ovf_q | acc_corr[ACC_W-1];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

`ifdef BCD_BLANK_EN
    // Blank a digit when it and every digit above it are zero; units always shown.
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (acc_d[4*k +: 4] == 4'd0);
      blank_d[k] = upper_zero;
    end
`endif
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
`ifdef BCD_BLANK_EN
  assign bus.blank     = blank_q;
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: 8-bit/3-digit and 8-bit/2-digit instances,
// expected results from a divide-by-ten model queued at accept and checked at output.
module tb_bcd_converter_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_converter_seq_if #(.BIN_W(8), .DIGITS(3)) bus_a ();
  bcd_converter_seq_if #(.BIN_W(8), .DIGITS(2)) bus_b ();

  bcd_converter_seq #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bcd_converter_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp  = 0;
  int n_fail = 0;
  logic [12:0] sb_a[$];
  logic [12:0] sb_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {overflow, bcd} by repeated division; bits above the digit count stay zero.
  function automatic logic [12:0] model(input int v, input int digits);
    logic [11:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return {rem != 0, r};
  endfunction

  task automatic run_a(input int v, input int hold);
    int cyc;
    int nbusy;
    logic [12:0] e;
    logic [11:0] bcd_seen;
    bus_a.out_ready = (hold == 0);
    cyc = 0;
    while (!bus_a.in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("a_in_ready_pre", 32'(bus_a.in_ready), 32'd1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'(v);
    sb_a.push_back(model(v, 3));
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = ~bus_a.in_data;
    cyc   = 0;
    nbusy = 0;
    while (!bus_a.out_valid && cyc < 40) begin
      if (bus_a.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check("a_latency", 32'(cyc), 32'd8);
    check("a_busy_cycles", 32'(nbusy), 32'd8);
    e = sb_a.pop_front();
    check("a_bcd", 32'(bus_a.bcd), 32'(e[11:0]));
    check("a_overflow", 32'(bus_a.overflow), 32'(e[12]));
`ifdef BCD_BLANK_EN
    check("a_blank", 32'(bus_a.blank),
          32'({e[11:8] == 4'd0, (e[11:8] == 4'd0) && (e[7:4] == 4'd0), 1'b0}));
`endif
    bcd_seen = bus_a.bcd;
    if (hold > 0) begin
      bus_a.in_data = 8'd42;
      for (int i = 0; i < hold; i++) begin
        bus_a.in_valid = 1'b1;
        @(negedge clk);
        check("a_hold_valid", 32'(bus_a.out_valid), 32'd1);
        check("a_hold_bcd", 32'(bus_a.bcd), 32'(bcd_seen));
        check("a_hold_in_ready", 32'(bus_a.in_ready), 32'd0);
      end
      bus_a.out_ready = 1'b1;
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check("a_post_valid", 32'(bus_a.out_valid), 32'd0);
    check("a_post_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("a_post_busy", 32'(bus_a.busy), 32'd0);
    check("a_post_bcd_kept", 32'(bus_a.bcd), 32'(bcd_seen));
  endtask

  task automatic run_b(input int v);
    int cyc;
    logic [12:0] e;
    bus_b.out_ready = 1'b1;
    cyc = 0;
    while (!bus_b.in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 8'(v);
    sb_b.push_back(model(v, 2));
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    cyc = 0;
    while (!bus_b.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b_latency", 32'(cyc), 32'd8);
    e = sb_b.pop_front();
    check("b_bcd", 32'(bus_b.bcd), 32'(e[7:0]));
    check("b_overflow", 32'(bus_b.overflow), 32'(e[12]));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_bcd", 32'(bus_a.bcd), 32'd0);
    check("rst_overflow", 32'(bus_a.overflow), 32'd0);
    check("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);
`ifdef BCD_BLANK_EN
    check("rst_blank", 32'(bus_a.blank), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_a(0, 0);
    run_a(255, 0);
    run_a(123, 5);

    // Reset in the middle of a conversion discards it.
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'd123;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(bus_a.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    check("mid_rst_bcd", 32'(bus_a.bcd), 32'd0);
    check("mid_rst_overflow", 32'(bus_a.overflow), 32'd0);
    run_a(7, 0);

    for (int i = 0; i < 256; i++) run_a(i, 0);

    run_b(200);
    run_b(99);
    run_b(0);
    run_b(255);

    check("sb_a_empty", 32'(sb_a.size()), 32'd0);
    check("sb_b_empty", 32'(sb_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
